// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding and load-use stall control for a single-issue ID->EX stage.
// Tracks the EX and MEM destination slots and selects the forwarding source for each EX operand.
module operand_fwd_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_we,
    input  logic        id_is_load,
    input  logic        id_b_sel_imm,
    input  logic        flush,
    output logic        ex_valid,
    output logic [1:0]  a_cmd,
    output logic [1:0]  b_cmd,
    output logic [1:0]  b_imm_cmd,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] MUX3_ZERO    = 2'd0;
    localparam logic [1:0] MUX3_DEFAULT = 2'd1;
    localparam logic [1:0] MUX3_TOP     = 2'd2;
    localparam logic [1:0] MUX3_BOTTOM  = 2'd3;

    localparam logic [1:0] MUX2_ZERO = 2'd0;
    localparam logic [1:0] MUX2_THIS = 2'd1;
    localparam logic [1:0] MUX2_THAT = 2'd2;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_STALL = 1'b1;

    logic       state, state_nxt;

    // ex_valid doubles as the EX slot valid bit.
    logic [4:0] ex_rd;
    logic       ex_we, ex_ld;
    logic       mem_v, mem_we;
    logic [4:0] mem_rd;

    logic       a_ex, a_mem, b_ex, b_mem;
    logic       hazard, issue, stall_hit;
    logic [1:0] a_sel, b_sel, b_imm_sel;

    function automatic logic slot_match(input logic v, input logic we,
                                        input logic [4:0] rd, input logic [4:0] rs);
        return v && we && (rd == rs) && (rs != 5'd0);
    endfunction

    always_comb begin
        a_ex  = slot_match(ex_valid, ex_we, ex_rd, id_rs1);
        a_mem = slot_match(mem_v, mem_we, mem_rd, id_rs1);
        b_ex  = slot_match(ex_valid, ex_we, ex_rd, id_rs2);
        b_mem = slot_match(mem_v, mem_we, mem_rd, id_rs2);
    end

    // EX is checked before MEM so the youngest producer wins.
    always_comb begin
        a_sel = MUX3_DEFAULT;
        if (id_rs1 == 5'd0)
            a_sel = MUX3_ZERO;
        else if (a_ex)
            a_sel = MUX3_TOP;
        else if (a_mem)
            a_sel = MUX3_BOTTOM;

        b_sel     = MUX3_DEFAULT;
        b_imm_sel = MUX2_THAT;
        if (!id_b_sel_imm) begin
            b_imm_sel = MUX2_THIS;
            if (id_rs2 == 5'd0)
                b_sel = MUX3_ZERO;
            else if (b_ex)
                b_sel = MUX3_TOP;
            else if (b_mem)
                b_sel = MUX3_BOTTOM;
        end
    end

    always_comb begin
        hazard    = id_valid && (state == ST_RUN) && ex_ld &&
                    (a_ex || (!id_b_sel_imm && b_ex));
        id_ready  = rst_n && !flush && !hazard;
        issue     = id_valid && id_ready;
        stall_hit = hazard && !flush;
        state_nxt = stall_hit ? ST_STALL : ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_we     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_v     <= 1'b0;
            mem_rd    <= '0;
            mem_we    <= 1'b0;
            a_cmd     <= MUX3_ZERO;
            b_cmd     <= MUX3_ZERO;
            b_imm_cmd <= MUX2_ZERO;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall_hit && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;

            mem_v  <= ex_valid && !flush;
            mem_rd <= ex_rd;
            mem_we <= ex_we;

            // issue is already false under flush, so this also inserts the flush bubble.
            ex_valid  <= issue;
            ex_rd     <= issue ? id_rd : 5'd0;
            ex_we     <= issue && id_rd_we;
            ex_ld     <= issue && id_is_load;
            a_cmd     <= issue ? a_sel : MUX3_ZERO;
            b_cmd     <= issue ? b_sel : MUX3_ZERO;
            b_imm_cmd <= issue ? b_imm_sel : MUX2_ZERO;
        end
    end

endmodule
